// File: rtl/gpc_pipe_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpc_pipe_acc                                                 |
// | Description : Pipelined two-column generalized parallel counter. Counts    |
// |               ones in src0 (weight 1) and src1 (weight 2) per beat, with   |
// |               optional multi-beat accumulation and a sticky overflow flag. |
// |               Two register stages (s1 + output) with valid/ready on both   |
// |               sides and full backpressure.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpc_pipe_acc #(
  parameter int H0    = 6,
  parameter int H1    = 1,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [H0-1:0]    src0,
  input  logic [H1-1:0]    src1,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] dst,
  output logic             out_ovf
);

  // Stage-1 registers: per-beat weighted count plus its run-control bits
  logic             s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0] s1_sum_q,   s1_sum_d;
  logic             s1_acc_q,   s1_acc_d;
  logic             s1_last_q,  s1_last_d;

  // Output registers and running accumulator
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] dst_q,       dst_d;
  logic             out_ovf_q,   out_ovf_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic             acc_ovf_q,   acc_ovf_d;

  logic [ACC_W-1:0] w_beat_sum;
  logic [ACC_W:0]   w_run_sum;
  logic             w_s1_emits;
  logic             w_s1_fire;
  logic             w_accept;

  // Weighted popcount of the incoming beat; ACC_W is wide enough for the maximum
  always_comb begin
    w_beat_sum = '0;
    for (int i = 0; i < H0; i++) begin
      w_beat_sum = w_beat_sum + ACC_W'(src0[i]);
    end
    for (int i = 0; i < H1; i++) begin
      w_beat_sum = w_beat_sum + (ACC_W'(src1[i]) << 1);
    end
  end

  // A beat emits unless it is a non-final accumulate beat. Absorbing beats
  // never touch the output register, so they may drain while it is stalled.
  assign w_s1_emits = !s1_acc_q || s1_last_q;
  assign w_s1_fire  = s1_valid_q && (!w_s1_emits || !out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || w_s1_fire;
  assign w_accept   = in_valid && in_ready;

  // One extra bit so the carry out of the accumulation can feed the sticky flag
  assign w_run_sum  = {1'b0, acc_q} + {1'b0, s1_sum_q};

  // Next-state logic for both pipeline stages and the accumulator
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_acc_d    = s1_acc_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    dst_d       = dst_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;

    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = w_beat_sum;
      s1_acc_d   = in_acc;
      s1_last_d  = in_last;
    end else if (w_s1_fire) begin
      s1_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // An emitting fire only happens when the output slot is free or draining,
    // so a held result is never overwritten here.
    if (w_s1_fire) begin
      if (!s1_acc_q) begin
        out_valid_d = 1'b1;
        dst_d       = s1_sum_q;
        out_ovf_d   = 1'b0;
      end else if (s1_last_q) begin
        out_valid_d = 1'b1;
        dst_d       = w_run_sum[ACC_W-1:0];
        out_ovf_d   = acc_ovf_q | w_run_sum[ACC_W];
        acc_d       = '0;
        acc_ovf_d   = 1'b0;
      end else begin
        acc_d       = w_run_sum[ACC_W-1:0];
        acc_ovf_d   = acc_ovf_q | w_run_sum[ACC_W];
      end
    end
  end

  // State registers; reset drops in-flight beats and any partial run
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_acc_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_acc_q    <= s1_acc_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      dst_q       <= dst_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire
